// File: rtl/uart_alu_frame_ctrl_if.sv
// Byte-stream and ALU operand bus between the UART command framer and its environment.
// master = framer side, slave = rx/tx/ALU side.
interface uart_alu_frame_ctrl_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned OP_W   = 6
);
   logic              rx_done_tick;
   logic [7:0]        rx_data;
   logic              tx_done_tick;
   logic              tx_start;
   logic [7:0]        tx_data;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [OP_W-1:0]   alu_op;
   logic [DATA_W-1:0] alu_result;
   logic              busy;
   logic              frame_err;
   logic              overrun;

   modport master (
      input  rx_done_tick, rx_data, tx_done_tick, alu_result,
      output tx_start, tx_data, alu_a, alu_b, alu_op, busy, frame_err, overrun
   );

   modport slave (
      output rx_done_tick, rx_data, tx_done_tick, alu_result,
      input  tx_start, tx_data, alu_a, alu_b, alu_op, busy, frame_err, overrun
   );
endinterface

// File: rtl/uart_alu_frame_ctrl.sv
// Command framer: opcode + LSB-first multi-byte A/B from UART rx, one ALU evaluation,
// LSB-first result bytes back out through the tx handshake.
module uart_alu_frame_ctrl #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned OP_W    = 6,
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic                  clk,
   input  logic                  reset,
   uart_alu_frame_ctrl_if.master bus
);
   localparam int unsigned NB       = DATA_W / 8;
   localparam int unsigned NBW      = (NB > 1) ? $clog2(NB) : 1;
   localparam int unsigned TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam logic [7:0]  OP_MASK  = 8'((32'd1 << OP_W) - 32'd1);

   typedef enum logic [2:0] {IDLE, RX_A, RX_B, EXEC, TX_LOAD, TX_WAIT} state_t;

   state_t            state, state_n;
   logic [NBW-1:0]    byte_cnt, byte_cnt_n;
   logic [NBW-1:0]    tx_idx, tx_idx_n;
   logic [TW-1:0]     tmo_cnt, tmo_n;
   logic [DATA_W-1:0] a_q, a_n, b_q, b_n, res_q, res_n;
   logic [OP_W-1:0]   op_q, op_n;
   logic [7:0]        tx_data_q, tx_data_n;
   logic              tx_start_q, tx_start_n;
   logic              busy_q, busy_n;
   logic              frame_err_q, frame_err_n;
   logic              overrun_q, overrun_n;
   logic              tmo_hit_c, last_byte_c;
   logic [NBW+2:0]    byte_sel_c, tx_sel_c;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         byte_cnt    <= '0;
         tx_idx      <= '0;
         tmo_cnt     <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         op_q        <= '0;
         tx_data_q   <= '0;
         tx_start_q  <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state       <= state_n;
         byte_cnt    <= byte_cnt_n;
         tx_idx      <= tx_idx_n;
         tmo_cnt     <= tmo_n;
         a_q         <= a_n;
         b_q         <= b_n;
         res_q       <= res_n;
         op_q        <= op_n;
         tx_data_q   <= tx_data_n;
         tx_start_q  <= tx_start_n;
         busy_q      <= busy_n;
         frame_err_q <= frame_err_n;
         overrun_q   <= overrun_n;
      end
   end

   always_comb begin
      state_n     = state;
      byte_cnt_n  = byte_cnt;
      tx_idx_n    = tx_idx;
      tmo_n       = tmo_cnt;
      a_n         = a_q;
      b_n         = b_q;
      res_n       = res_q;
      op_n        = op_q;
      tx_data_n   = tx_data_q;
      tx_start_n  = 1'b0;
      frame_err_n = 1'b0;
      overrun_n   = 1'b0;
      tmo_hit_c   = (TIMEOUT != 0) && (tmo_cnt == TW'(TMO_LAST));
      last_byte_c = (byte_cnt == NBW'(NB - 1));
      byte_sel_c  = {byte_cnt, 3'b000};
      tx_sel_c    = {tx_idx, 3'b000};

      case (state)
         IDLE: begin
            if (bus.rx_done_tick) begin
               if ((bus.rx_data & ~OP_MASK) != 8'h00) begin
                  frame_err_n = 1'b1;
               end else begin
                  op_n       = bus.rx_data[OP_W-1:0];
                  byte_cnt_n = '0;
                  tmo_n      = '0;
                  state_n    = RX_A;
               end
            end
         end
         RX_A, RX_B: begin
            // A byte on the terminal timeout cycle still counts
            if (bus.rx_done_tick) begin
               tmo_n = '0;
               if (state == RX_A) a_n[byte_sel_c +: 8] = bus.rx_data;
               else               b_n[byte_sel_c +: 8] = bus.rx_data;
               if (last_byte_c) begin
                  byte_cnt_n = '0;
                  state_n    = (state == RX_A) ? RX_B : EXEC;
               end else begin
                  byte_cnt_n = byte_cnt + NBW'(1);
               end
            end else if (tmo_hit_c) begin
               frame_err_n = 1'b1;
               state_n     = IDLE;
            end else begin
               tmo_n = tmo_cnt + TW'(1);
            end
         end
         EXEC: begin
            res_n    = bus.alu_result;
            tx_idx_n = '0;
            state_n  = TX_LOAD;
         end
         TX_LOAD: begin
            tx_data_n  = res_q[tx_sel_c +: 8];
            tx_start_n = 1'b1;
            state_n    = TX_WAIT;
         end
         TX_WAIT: begin
            if (bus.tx_done_tick) begin
               if (tx_idx == NBW'(NB - 1)) begin
                  state_n = IDLE;
               end else begin
                  tx_idx_n = tx_idx + NBW'(1);
                  state_n  = TX_LOAD;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // Bytes arriving while a result is in flight are dropped and flagged
      if (bus.rx_done_tick && (state == EXEC || state == TX_LOAD || state == TX_WAIT))
         overrun_n = 1'b1;

      busy_n = (state_n != IDLE);
   end

   assign bus.tx_start  = tx_start_q;
   assign bus.tx_data   = tx_data_q;
   assign bus.alu_a     = a_q;
   assign bus.alu_b     = b_q;
   assign bus.alu_op    = op_q;
   assign bus.busy      = busy_q;
   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Directed bench for uart_alu_frame_ctrl: frames in, scoreboarded result bytes out,
// plus bad opcode, timeout, overrun and asynchronous reset scenarios.
module tb_uart_alu_frame_ctrl;
   localparam int unsigned DATA_W  = 16;
   localparam int unsigned OP_W    = 6;
   localparam int unsigned TIMEOUT = 100;
   localparam int unsigned NB      = DATA_W / 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   uart_alu_frame_ctrl_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

   uart_alu_frame_ctrl #(.DATA_W(DATA_W), .OP_W(OP_W), .TIMEOUT(TIMEOUT)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.master)
   );

   function automatic logic [DATA_W-1:0] alu_model(input logic [OP_W-1:0] op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         default: return '0;
      endcase
   endfunction

   assign bus.alu_result = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);

   int checks = 0;
   int errors = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int ts_cnt = 0;
   logic [7:0] exp_q[$];

   // Pulse counters, sampled on the active edge (sees the previous cycle's value)
   always @(posedge clk) begin
      if (bus.frame_err === 1'b1) fe_cnt++;
      if (bus.overrun   === 1'b1) ov_cnt++;
      if (bus.tx_start  === 1'b1) ts_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick_rx(input logic [7:0] b);
      @(negedge clk);
      bus.rx_data      = b;
      bus.rx_done_tick = 1'b1;
      @(negedge clk);
      bus.rx_done_tick = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] op, input logic [DATA_W-1:0] a,
                             input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] res;
      res = alu_model(op[OP_W-1:0], a, b);
      for (int i = 0; i < int'(NB); i++) exp_q.push_back(res[8*i +: 8]);
      tick_rx(op);
      idle(2);
      for (int i = 0; i < int'(NB); i++) tick_rx(a[8*i +: 8]);
      idle(1);
      for (int i = 0; i < int'(NB); i++) tick_rx(b[8*i +: 8]);
   endtask

   // Plays the tx module; optionally injects an rx byte while the first byte is on the wire
   task automatic serve_tx(input bit inject);
      int waited;
      logic [7:0] held;
      logic [7:0] exp;
      for (int idx = 0; idx < int'(NB); idx++) begin
         if (idx == 0) begin
            waited = 0;
            while (bus.tx_start !== 1'b1 && waited < 20) begin
               @(negedge clk);
               waited++;
            end
            check("tx_start_latency_first", 64'(waited), 64'd2);
         end else begin
            @(negedge clk);
            check("tx_start_latency_next", 64'(bus.tx_start), 64'd1);
         end
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         check("tx_data", 64'(bus.tx_data), 64'(exp));
         held = bus.tx_data;
         for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            if (inject && idx == 0 && g == 0) begin
               bus.rx_data      = 8'hEE;
               bus.rx_done_tick = 1'b1;
            end else begin
               bus.rx_done_tick = 1'b0;
            end
            check("tx_start_quiet", 64'(bus.tx_start), 64'd0);
         end
         check("tx_data_hold", 64'(bus.tx_data), 64'(held));
         @(negedge clk);
         bus.tx_done_tick = 1'b1;
         @(negedge clk);
         bus.tx_done_tick = 1'b0;
      end
      check("busy_after_tx", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      int fe0, ov0, ts0, hit;
      reset            = 1'b1;
      bus.rx_done_tick = 1'b0;
      bus.rx_data      = 8'h00;
      bus.tx_done_tick = 1'b0;
      idle(2);
      check("reset_flags", 64'({bus.tx_start, bus.busy, bus.frame_err, bus.overrun}), 64'd0);
      check("reset_data", 64'({bus.tx_data, bus.alu_op, bus.alu_a, bus.alu_b}), 64'd0);
      reset = 1'b0;
      idle(2);

      // Basic frame: 0x1234 + 0x0101
      fe0 = fe_cnt; ov0 = ov_cnt;
      send_frame(8'h20, 16'h1234, 16'h0101);
      check("frame1_busy", 64'(bus.busy), 64'd1);
      serve_tx(1'b0);
      check("frame1_alu_a", 64'(bus.alu_a), 64'h1234);
      check("frame1_alu_b", 64'(bus.alu_b), 64'h0101);
      check("frame1_alu_op", 64'(bus.alu_op), 64'h20);
      idle(2);

      // Signed wrap
      send_frame(8'h20, 16'h7FFF, 16'h0001);
      serve_tx(1'b0);
      idle(2);
      check("wrap_no_frame_err", 64'(fe_cnt - fe0), 64'd0);
      check("wrap_no_overrun", 64'(ov_cnt - ov0), 64'd0);

      // Bad opcode, then a valid subtract frame
      fe0 = fe_cnt; ts0 = ts_cnt;
      tick_rx(8'hC2);
      check("bad_op_pulse", 64'(bus.frame_err), 64'd1);
      check("bad_op_idle", 64'(bus.busy), 64'd0);
      idle(1);
      check("bad_op_single", 64'(bus.frame_err), 64'd0);
      idle(3);
      check("bad_op_count", 64'(fe_cnt - fe0), 64'd1);
      check("bad_op_no_tx", 64'(ts_cnt - ts0), 64'd0);
      send_frame(8'h22, 16'h0005, 16'h0007);
      serve_tx(1'b0);
      idle(2);

      // Inter-byte timeout
      fe0 = fe_cnt; hit = 0;
      tick_rx(8'h20);
      idle(2);
      tick_rx(8'h34);
      for (int i = 1; i <= 150; i++) begin
         @(negedge clk);
         if (bus.frame_err === 1'b1) begin
            hit = i;
            break;
         end
      end
      check("timeout_cycle", 64'(hit), 64'(TIMEOUT));
      check("timeout_idle", 64'(bus.busy), 64'd0);
      idle(3);
      check("timeout_count", 64'(fe_cnt - fe0), 64'd1);
      send_frame(8'h20, 16'hA5A5, 16'h1111);
      serve_tx(1'b0);
      idle(2);

      // Overrun while transmitting
      ov0 = ov_cnt;
      send_frame(8'h20, 16'h00FF, 16'h0001);
      serve_tx(1'b1);
      idle(2);
      check("overrun_count", 64'(ov_cnt - ov0), 64'd1);

      // Asynchronous reset in RX_B
      ts0 = ts_cnt;
      tick_rx(8'h20);
      tick_rx(8'h34);
      tick_rx(8'h12);
      tick_rx(8'h01);
      check("pre_reset_busy", 64'(bus.busy), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("async_reset_outputs",
            64'({bus.busy, bus.frame_err, bus.overrun, bus.tx_start,
                 bus.alu_op, bus.alu_a, bus.alu_b, bus.tx_data}), 64'd0);
      idle(2);
      reset = 1'b0;
      idle(6);
      check("reset_abort_no_tx", 64'(ts_cnt - ts0), 64'd0);
      send_frame(8'h20, 16'h0102, 16'h0304);
      serve_tx(1'b0);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
